// File: rtl/simple_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : simple_uart_tx_arbiter                                       |
// | Description : Round-robin arbiter sharing one byte-write UART transmitter  |
// |               among NUM_REQ valid/ready byte producers.                    |
// |               Optional message lock: SIMPLE_UART_TX_ARB_LOCK_EN            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module simple_uart_tx_arbiter #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  arst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [7:0]            uart_tx_value,
  output logic                  uart_tx_value_write,
  input  logic                  uart_tx_value_done,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic                  busy
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  ,
  output logic                  lock_active
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WRITE     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ID_WIDTH-1:0] r_last_grant;
  logic [ID_WIDTH-1:0] w_winner;
  logic [ID_WIDTH-1:0] w_cand;
  logic                w_grant_valid;
  logic                w_accept;

`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  logic                r_lock_active;
  logic                r_last_byte;
  assign lock_active = r_lock_active;
`else
  logic                w_unused_last;
  assign w_unused_last = ^req_last;
`endif

  // Descending scan so the candidate closest after last_grant is assigned last and wins.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = ID_WIDTH'((int'(r_last_grant) + k) % NUM_REQ);
      if (req_valid[w_cand]) w_winner = w_cand;
    end
  end

  assign w_grant_valid       = req_valid[grant_id];
  assign w_accept            = (r_state == S_ISSUE) && w_grant_valid;
  assign uart_tx_value_write = (r_state == S_WRITE);
  assign busy                = (r_state != S_IDLE);

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_grant_valid) begin
          w_state_next = S_WRITE;
        end else begin
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
          if (!r_lock_active) w_state_next = S_IDLE;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
      S_WRITE: begin
        w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (uart_tx_value_done) begin
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
          w_state_next = r_last_byte ? S_IDLE : S_ISSUE;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pointer resets to NUM_REQ-1 so requester 0 is the first winner.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= S_IDLE;
      grant_id      <= '0;
      r_last_grant  <= ID_WIDTH'(NUM_REQ - 1);
      uart_tx_value <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && (|req_valid)) grant_id <= w_winner;
      if (w_accept) begin
        uart_tx_value <= req_data[8*grant_id +: 8];
        r_last_grant  <= grant_id;
      end
    end
  end

`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_lock_active <= 1'b0;
      r_last_byte   <= 1'b0;
    end else if (w_accept) begin
      r_lock_active <= 1'b1;
      r_last_byte   <= req_last[grant_id];
    end else if ((r_state == S_WAIT_DONE) && uart_tx_value_done && r_last_byte) begin
      r_lock_active <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_simple_uart_tx_arbiter                                    |
// | Description : Scoreboard bench for simple_uart_tx_arbiter with randomized  |
// |               requesters and a behavioural round-robin service model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_simple_uart_tx_arbiter;

  localparam int N = 4;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             arst_n;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [7:0]       uart_tx_value;
  logic             uart_tx_value_write;
  logic             uart_tx_value_done;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
  logic             lock_active;
`endif

  always #5 clock = ~clock;

  simple_uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clock               (clock),
    .arst_n              (arst_n),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_last            (req_last),
    .req_ready           (req_ready),
    .uart_tx_value       (uart_tx_value),
    .uart_tx_value_write (uart_tx_value_write),
    .uart_tx_value_done  (uart_tx_value_done),
    .grant_id            (grant_id),
    .busy                (busy)
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    ,
    .lock_active         (lock_active)
`endif
  );

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bq[N][$];
  int         tests = 0;
  int         fails = 0;
  int         model_last = N - 1;
  bit         hold = 1'b0;
  bit         spurious_en = 1'b0;
  bit         prev_rdy = 1'b0;
  logic [N-1:0] drv_rdy;
  int         cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic present(input int i);
    if (bq[i].size() > 0) begin
      req_valid[i]       = 1'b1;
      req_data[8*i +: 8] = bq[i][0];
      req_last[i]        = (bq[i].size() == 1);
    end else begin
      req_valid[i] = 1'b0;
      req_last[i]  = 1'b0;
    end
  endtask

  // Requester driver: a byte leaves its queue when its ready strobe is seen.
  initial begin
    forever begin
      @(negedge clock);
      drv_rdy = req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (drv_rdy[i]) begin
          void'(bq[i].pop_front());
          present(i);
        end
      end
    end
  end

  // UART stand-in: done arrives 1..6 cycles after a write; optional stray dones while idle.
  initial begin
    bit w;
    uart_tx_value_done = 1'b0;
    forever begin
      @(negedge clock);
      w = uart_tx_value_write;
      uart_tx_value_done = 1'b0;
      if (w && !hold) begin
        cnt = $urandom_range(1, 6);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) uart_tx_value_done = 1'b1;
      end else if (spurious_en && ($urandom_range(0, 15) == 0)) begin
        uart_tx_value_done = 1'b1;
      end
    end
  end

  // Monitor: checks every accept strobe and write pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!arst_n) begin
        prev_rdy = 1'b0;
        continue;
      end
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 1);
        if (exp_q.size() == 0) chk("unexpected_ready", 32'(req_ready), 0);
        else                   chk("ready_id", 32'(req_ready), 32'(1) << exp_q[0].id);
      end
      if (uart_tx_value_write || prev_rdy)
        chk("write_latency", 32'(uart_tx_value_write), 32'(prev_rdy));
      if (uart_tx_value_write) begin
        chk("busy_at_write", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(uart_tx_value_write), 0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(uart_tx_value), 32'(e.b));
          chk("write_grant_id", 32'(grant_id), e.id);
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
          chk("lock_active_at_write", 32'(lock_active), 1);
`endif
        end
      end
      prev_rdy = |req_ready;
    end
  end

  task automatic fill_random(input logic [N-1:0] mask);
    int n;
    for (int i = 0; i < N; i++) begin
      n = mask[i] ? $urandom_range(1, 3) : 0;
      for (int k = 0; k < n; k++) bq[i].push_back(8'($urandom_range(0, 255)));
    end
  endtask

  // Service-order model: next requester after the pointer that still holds bytes;
  // with message lock the whole queue of a requester is one message.
  task automatic model_push();
    int   rem[N];
    int   pos[N];
    int   ptr;
    int   j;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      rem[i] = bq[i].size();
      pos[i] = 0;
    end
    ptr = model_last;
    while (1) begin
      j = -1;
      for (int k = 1; k <= N; k++)
        if (j < 0 && rem[(ptr + k) % N] > 0) j = (ptr + k) % N;
      if (j < 0) break;
      do begin
        e.id = j;
        e.b  = bq[j][pos[j]];
        exp_q.push_back(e);
        pos[j]++;
        rem[j]--;
      end while (LOCK && rem[j] > 0);
      ptr = j;
    end
    model_last = ptr;
  endtask

  task automatic run_round();
    bit ok;
    bit empty;
    model_push();
    @(posedge clock);
    #2;
    for (int i = 0; i < N; i++) present(i);
    ok = 1'b0;
    for (int cyc = 0; cyc < 3000 && !ok; cyc++) begin
      @(negedge clock);
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (bq[i].size() != 0) empty = 1'b0;
      if (exp_q.size() == 0 && !busy && empty) ok = 1'b1;
    end
    chk("round_complete", 32'(ok), 1);
    if (!ok) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) bq[i].delete();
      req_valid = '0;
    end
  endtask

  initial begin
    bit seen;
    arst_n    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_write", 32'(uart_tx_value_write), 0);
    chk("rst_value", 32'(uart_tx_value), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    chk("rst_lock_active", 32'(lock_active), 0);
`endif
    arst_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single byte from requester 2.
    bq[2].push_back(8'hA5);
    run_round();
    chk("single_grant_id", 32'(grant_id), 2);

    // All four requesters, two bytes each.
    for (int i = 0; i < N; i++) begin
      bq[i].push_back(8'(8'h10 + i));
      bq[i].push_back(8'(8'h20 + i));
    end
    run_round();

    // Pointer wrap: grant 3, then 0 and 3 together.
    bq[3].push_back(8'h33);
    run_round();
    bq[0].push_back(8'h40);
    bq[3].push_back(8'h43);
    run_round();

    // Valid withdrawn before ISSUE: no accept, pointer untouched.
    @(posedge clock);
    #2;
    req_valid[1]       = 1'b1;
    req_data[15:8]     = 8'h77;
    @(posedge clock);
    #2;
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clock);
    chk("withdraw_grant_id", 32'(grant_id), 1);
    chk("withdraw_busy", 32'(busy), 0);
    for (int i = 0; i < N; i++) bq[i].push_back(8'(8'h50 + i));
    run_round();

    // Reset while waiting for done.
    hold = 1'b1;
    bq[1].push_back(8'h5A);
    model_push();
    @(posedge clock);
    #2;
    present(1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clock);
      if (exp_q.size() == 0) seen = 1'b1;
    end
    chk("stall_write_seen", 32'(seen), 1);
    repeat (4) @(negedge clock);
    chk("stall_busy", 32'(busy), 1);
    @(posedge clock);
    #3;
    arst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_write", 32'(uart_tx_value_write), 0);
    chk("arst_value", 32'(uart_tx_value), 0);
    chk("arst_grant_id", 32'(grant_id), 0);
    chk("arst_busy", 32'(busy), 0);
`ifdef SIMPLE_UART_TX_ARB_LOCK_EN
    chk("arst_lock_active", 32'(lock_active), 0);
`endif
    exp_q.delete();
    for (int i = 0; i < N; i++) bq[i].delete();
    req_valid = '0;
    req_last  = '0;
    @(negedge clock);
    arst_n     = 1'b1;
    hold       = 1'b0;
    model_last = N - 1;
    for (int i = 0; i < N; i++) bq[i].push_back(8'(8'h60 + i));
    run_round();

    // Randomized rounds with stray done pulses while idle.
    spurious_en = 1'b1;
    repeat (25) begin
      fill_random(N'($urandom_range(1, (1 << N) - 1)));
      run_round();
    end
    spurious_en = 1'b0;

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
